// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID 2-entry skid buffer with valid/ready, flush, NOP bubbles and a saturating stall counter
module if_id_skid_reg #(
  parameter int INSTR_W = 16,
  parameter int PC_W = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0000,
  parameter int STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc_plus_two,
  input  logic [INSTR_W-1:0]     in_instruction,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc_plus_two,
  output logic [INSTR_W-1:0]     out_instruction,
  output logic [STALL_CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;
  state_t state, nxt;
  logic acc, con, ld_in, ld_skid;
  logic [INSTR_W-1:0] skid_ins, ins_d;
  logic [PC_W-1:0] skid_pc, pc_d;
  assign out_valid = state[0];
  assign in_ready = ~state[1];
  always_comb begin
    acc = in_valid & in_ready;
    con = out_valid & out_ready;
    ld_in = acc & (~out_valid | con);
    ld_skid = state[1] & con;
    nxt = flush ? EMPTY : ld_in ? ONE : acc ? FULL : ld_skid ? ONE : con ? EMPTY : state;
    ins_d = nxt == EMPTY ? NOP_INSTR : ld_in ? in_instruction : ld_skid ? skid_ins : out_instruction;
    pc_d = nxt == EMPTY ? '0 : ld_in ? in_pc_plus_two : ld_skid ? skid_pc : out_pc_plus_two;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      out_instruction <= NOP_INSTR;
      out_pc_plus_two <= '0;
      skid_ins <= '0;
      skid_pc <= '0;
      stall_count <= '0;
    end else begin
      state <= nxt;
      out_instruction <= ins_d;
      out_pc_plus_two <= pc_d;
      if (acc) begin
        skid_ins <= in_instruction;
        skid_pc <= in_pc_plus_two;
      end
      if (out_valid & ~out_ready & ~&stall_count) stall_count <= stall_count + 1'b1;
    end
  end
endmodule
